// File: rtl/led_sequencer.sv
// led_sequencer: Avalon-MM slave that queues LED patterns in a FIFO and
// plays them onto the LED pins. Each pattern is held for a programmable
// dwell time, with optional recirculation of popped patterns for looping.
module led_sequencer #(
  parameter int          LED_W     = 10,
  parameter int          DEPTH     = 16,
  parameter logic [31:0] DWELL_RST = 32'd50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       avs_address,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  output logic             avs_waitrequest,
  output logic [LED_W-1:0] leds
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SHOW} state_t;

  // Pattern storage and FIFO bookkeeping
  logic [LED_W-1:0] fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Control/status registers
  logic [31:0]      dwell_reg;
  logic             run_reg, loop_reg, ovf_reg;
  logic [31:0]      readdata_reg;

  // Playback state
  state_t           state_reg, state_next;
  logic [31:0]      cnt_reg, cnt_next;
  logic [LED_W-1:0] leds_reg, leds_next;

  // Decoded strobes and FIFO handshakes
  logic             wr_pat, wr_dwell, wr_ctrl, wr_stat, clear;
  logic             empty, full, pop, loop_push, cpu_push, push, ovf_set;
  logic [LED_W-1:0] head, push_data;
  logic [31:0]      dwell_load;
  logic [31:0]      rd_mux;

  assign wr_pat   = avs_write && (avs_address == 2'd0);
  assign wr_dwell = avs_write && (avs_address == 2'd1);
  assign wr_ctrl  = avs_write && (avs_address == 2'd2);
  assign wr_stat  = avs_write && (avs_address == 2'd3);
  // Clear has no storage: it acts on the edge that samples the CTRL write.
  assign clear    = wr_ctrl && avs_writedata[2];

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CW'(DEPTH));
  // Head is read combinationally so it can be shown on the pop edge itself.
  assign head       = fifo_mem[rd_ptr_reg];
  // A programmed dwell of 0 behaves like 1 (counter reloads to 0).
  assign dwell_load = (dwell_reg == 32'd0) ? 32'd0 : dwell_reg - 32'd1;

  // Next-state logic: pop the head when idle or when the dwell expires
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    leds_next  = leds_reg;
    pop        = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (run_reg && !empty) begin
            pop        = 1'b1;
            leds_next  = head;
            cnt_next   = dwell_load;
            state_next = SHOW;
          end
        end
        SHOW: begin
          if (cnt_reg != 32'd0) begin
            cnt_next = cnt_reg - 32'd1;
          end else if (run_reg && !empty) begin
            pop       = 1'b1;
            leds_next = head;
            cnt_next  = dwell_load;
          end else begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Loop recirculation owns the write port on a pop edge; a coinciding CPU
  // pattern write is stalled for that cycle instead of being dropped.
  assign loop_push       = pop && loop_reg;
  assign avs_waitrequest = wr_pat && loop_push;
  // A push alongside a pop is legal even when full.
  assign cpu_push        = wr_pat && !loop_push && !clear && (!full || pop);
  assign ovf_set         = wr_pat && !loop_push && full && !pop;
  assign push            = loop_push || cpu_push;
  assign push_data       = loop_push ? head : avs_writedata[LED_W-1:0];

  // FSM, counter and LED output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      leds_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      leds_reg  <= leds_next;
    end
  end

  // Pattern storage; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      fifo_mem[wr_ptr_reg] <= push_data;
    end
  end

  // FIFO pointers and occupancy; clear beats any push or pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Software-visible control registers and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_reg <= DWELL_RST;
      run_reg   <= 1'b0;
      loop_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (wr_dwell) dwell_reg <= avs_writedata;
      if (wr_ctrl) begin
        run_reg  <= avs_writedata[0];
        loop_reg <= avs_writedata[1];
      end
      if (wr_stat)      ovf_reg <= 1'b0;
      else if (ovf_set) ovf_reg <= 1'b1;
    end
  end

  // Read-side register mux; unused bits stay zero
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux[LED_W-1:0] = leds_reg;
      2'd1: rd_mux = dwell_reg;
      2'd2: rd_mux[1:0] = {loop_reg, run_reg};
      default: begin
        rd_mux[0]      = empty;
        rd_mux[1]      = full;
        rd_mux[2]      = (state_reg == SHOW);
        rd_mux[3]      = ovf_reg;
        rd_mux[8 +: CW] = count_reg;
      end
    endcase
  end

  // Read data register: latency 1, holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_reg <= '0;
    end else if (avs_read) begin
      readdata_reg <= rd_mux;
    end
  end

  assign avs_readdata = readdata_reg;
  assign leds         = leds_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: a register-access vector table
// followed by hand-timed playback, overflow, loop, clear and reset sequences.
module tb_led_sequencer;

  localparam int          LED_W     = 10;
  localparam int          DEPTH     = 16;
  localparam logic [31:0] DWELL_RST = 32'd50_000_000;

  logic             clk;
  logic             reset;
  logic [1:0]       avs_address;
  logic             avs_write;
  logic [31:0]      avs_writedata;
  logic             avs_read;
  logic [31:0]      avs_readdata;
  logic             avs_waitrequest;
  logic [LED_W-1:0] leds;

  int n_checks = 0;
  int n_fail   = 0;

  led_sequencer #(.LED_W(LED_W), .DEPTH(DEPTH), .DWELL_RST(DWELL_RST)) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_address     (avs_address),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_read        (avs_read),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .leds            (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Avalon write honouring waitrequest; returns #1 after the accepting edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stalls);
    logic st;
    int   guard;
    stalls = 0;
    guard  = 0;
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    do begin
      @(negedge clk);
      st = avs_waitrequest;
      @(posedge clk);
      #1;
      if (st) stalls++;
      guard++;
    end while (st && guard < 50);
    avs_write = 1'b0;
    if (st) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: addr %0d still stalled after %0d cycles", a, guard);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  // Avalon read; returns #1 after the sampling edge with the registered data
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    v = avs_readdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [31:0] e, input string n);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.exp = e; v.name = n;
    vq.push_back(v);
  endtask

  logic [31:0]      rv;
  logic [LED_W-1:0] seq_abc [3];
  logic [LED_W-1:0] saved;
  int               stalls;

  initial begin
    reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;

    // Register access vectors from reset (run stays 0 until the end)
    add_vec(1'b0, 2'd3, 32'h0,    32'h0000_0001, "rd_status_reset");
    add_vec(1'b0, 2'd1, 32'h0,    DWELL_RST,     "rd_dwell_reset");
    add_vec(1'b0, 2'd0, 32'h0,    32'h0000_0000, "rd_pattern_reset");
    add_vec(1'b0, 2'd2, 32'h0,    32'h0000_0000, "rd_ctrl_reset");
    add_vec(1'b1, 2'd1, 32'h1234, 32'h0,         "wr_dwell");
    add_vec(1'b0, 2'd1, 32'h0,    32'h0000_1234, "rd_dwell");
    add_vec(1'b1, 2'd2, 32'h2,    32'h0,         "wr_ctrl_loop");
    add_vec(1'b0, 2'd2, 32'h0,    32'h0000_0002, "rd_ctrl_loop");
    add_vec(1'b1, 2'd2, 32'hFE,   32'h0,         "wr_ctrl_clear_bits");
    add_vec(1'b0, 2'd2, 32'h0,    32'h0000_0002, "rd_ctrl_clear_reads0");
    add_vec(1'b1, 2'd2, 32'h0,    32'h0,         "wr_ctrl_zero");
    add_vec(1'b0, 2'd2, 32'h0,    32'h0000_0000, "rd_ctrl_zero");
    add_vec(1'b1, 2'd1, 32'h0,    32'h0,         "wr_dwell_zero");
    add_vec(1'b0, 2'd1, 32'h0,    32'h0000_0000, "rd_dwell_zero");

    repeat (3) @(posedge clk);
    #1;
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);
    check("reset_waitrequest", 32'(avs_waitrequest), 32'h0);
    reset = 1'b0;
    step();

    foreach (vq[i]) begin
      if (vq[i].is_wr) begin
        wr(vq[i].addr, vq[i].data);
        $display("wr   %s: addr %0d data 0x%08h", vq[i].name, vq[i].addr, vq[i].data);
      end else begin
        rd(vq[i].addr, rv);
        check(vq[i].name, rv, vq[i].exp);
      end
    end

    // Basic playback with DWELL=3
    wr(2'd1, 32'd3);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h155);
    check("play_not_yet", 32'(leds), 32'h0);
    wr(2'd0, 32'h2AA);
    check("play_first", 32'(leds), 32'h155);
    step(); check("play_hold1", 32'(leds), 32'h155);
    step(); check("play_hold2", 32'(leds), 32'h155);
    step(); check("play_second", 32'(leds), 32'h2AA);
    step(); step();
    rd(2'd3, rv); check("play_status_busy", rv, 32'h0000_0005);
    rd(2'd3, rv); check("play_status_idle", rv, 32'h0000_0001);
    check("play_leds_held", 32'(leds), 32'h2AA);

    // Overflow with run off
    wr(2'd2, 32'h0);
    for (int i = 0; i <= DEPTH; i++) wr(2'd0, 32'h100 + 32'(i));
    rd(2'd3, rv); check("ovf_status_full", rv, 32'h0000_100A);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, rv); check("ovf_status_cleared", rv, 32'h0000_1002);
    wr(2'd1, 32'd1);
    wr(2'd2, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check($sformatf("drain_%0d", i), 32'(leds), 32'h100 + 32'(i));
    end
    step(); check("drain_no_17th", 32'(leds), 32'h10F);
    rd(2'd3, rv); check("drain_status", rv, 32'h0000_0001);

    // Loop mode with DWELL=2 and a collision
    seq_abc[0] = 10'h0A1; seq_abc[1] = 10'h0B2; seq_abc[2] = 10'h0C3;
    wr(2'd2, 32'h0);
    wr(2'd1, 32'd2);
    for (int i = 0; i < 3; i++) wr(2'd0, 32'(seq_abc[i]));
    wr(2'd2, 32'h3);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("loop_%0d", i), 32'(leds), 32'(seq_abc[(i / 2) % 3]));
    end
    rd(2'd3, rv); check("loop_count3", rv, 32'h0000_0304);
    step();
    bus_write(2'd0, 32'h0D4, stalls);
    check("loop_collision_stalls", 32'(stalls), 32'd1);
    rd(2'd3, rv); check("loop_count4", rv, 32'h0000_0404);

    // Clear on a pop edge: FIFO empties, leds keep their value
    step();
    saved = leds;
    wr(2'd2, 32'h5);
    check("clear_leds_kept", 32'(leds), 32'(saved));
    rd(2'd3, rv); check("clear_status", rv, 32'h0000_0001);

    // DWELL=0 acts as 1
    wr(2'd2, 32'h0);
    wr(2'd1, 32'd0);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h301 + 32'(i));
    wr(2'd2, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("dwell0_%0d", i), 32'(leds), 32'h301 + 32'(i));
    end
    step(); check("dwell0_hold", 32'(leds), 32'h304);

    // Asynchronous reset mid-SHOW
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h3FF);
    step(); check("rst_show_leds", 32'(leds), 32'h3FF);
    step();
    reset = 1'b1;
    #1;
    check("rst_async_leds", 32'(leds), 32'h0);
    check("rst_async_readdata", avs_readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd(2'd3, rv); check("rst_status", rv, 32'h0000_0001);
    rd(2'd1, rv); check("rst_dwell", rv, DWELL_RST);
    rd(2'd2, rv); check("rst_ctrl", rv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Avalon-MM slave peripheral that sits directly downstream of the Nios II system bus. It drives the board LEDs.
- The CPU pushes LED patterns into an internal FIFO.
- The block plays the patterns onto the LED pins, holding each one for a programmable dwell time. It can optionally recirculate patterns for continuous looping.

Parameters:
- LED_W, 10, LED/pattern width (1..32)
- DEPTH, 16, pattern FIFO depth; power of 2, 2..256
- DWELL_RST, 50000000, dwell register reset value (cycles per pattern)

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  asynchronous, active-high reset
- avs_address  input  2  register select
- avs_write  input  1  write strobe
- avs_writedata  input  32  write data
- avs_read  input  1  read strobe
- avs_readdata  output  32  read data, registered, fixed read latency 1
- avs_waitrequest  output  1  stall; asserted only on a loop-push collision
- leds  output  LED_W  registered LED drive

Behaviour:
- Register map, write side:
  - 0 PATTERN (W): push writedata[LED_W-1:0] into the FIFO.
  - 1 DWELL (R/W): 32-bit dwell count. A value of 0 is treated as 1.
  - 2 CTRL (R/W): bit0 run, bit1 loop, bit2 clear. Clear is self-clearing and reads 0.
  - 3 STATUS (W): writing any value clears the overflow flag.
- Register map, read side:
  - 0 PATTERN (R): current leds value.
  - 3 STATUS (R): bit0 empty, bit1 full, bit2 busy (FSM in SHOW), bit3 overflow (sticky), bits[16:8] FIFO count.
  - All unused bits read 0.
- Reset: leds=0, FIFO empty, CTRL=0, DWELL=DWELL_RST, overflow=0, avs_readdata=0, avs_waitrequest=0, FSM=IDLE.
- Reads: avs_readdata updates on the edge where avs_read=1. It holds its value otherwise. Reads have no side effects.
- Pattern write when full: data is dropped, overflow is set, count is unchanged, and no waitrequest is raised.
- FIFO: circular buffer with write/read pointers and a count of width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH. A push and a pop in the same cycle leave count unchanged and are legal even when full.
- FSM IDLE:
  - leds hold their last value.
  - If run=1 and FIFO not empty: pop the head, load leds with it, load the counter with max(DWELL,1)-1, go to SHOW.
  - A pattern accepted at edge N therefore appears on leds at edge N+1.
- FSM SHOW:
  - The counter decrements each cycle.
  - When counter==0 and run=1 and not empty: pop the next head into leds, reload the counter, stay in SHOW.
  - When counter==0 otherwise: go to IDLE.
  - Each pattern is therefore visible for exactly max(DWELL,1) cycles when the FIFO is kept fed.
- Loop mode: when loop=1, every popped pattern is pushed back to the FIFO tail on the same edge, so count is unchanged.
- Collision: if a CPU PATTERN write coincides with a loop push, avs_waitrequest=1 for that cycle. The CPU write is accepted on the next cycle.
- run cleared during SHOW: the current dwell completes, then the FSM goes to IDLE without popping.
- DWELL written during SHOW: takes effect at the next counter load.
- Clear:
  - On the edge after a CTRL write with bit2=1: FIFO empties (pointers and count to 0), FSM goes to IDLE, leds retain their value.
  - Clear takes priority over any push or pop in the same cycle.
- Reset asserted mid-operation: everything returns to reset values immediately. There is no partial state.

Test Plan:
- Reset, then read STATUS -> readdata=0x00000001 (empty). leds=0. DWELL read = DWELL_RST.
- DWELL=3, CTRL=1, then write patterns 0x155, 0x2AA -> leds=0x155 one cycle after the first accept. After exactly 3 cycles leds=0x2AA; 3 cycles later FSM is IDLE and leds stay 0x2AA. STATUS busy=0, empty=1.
- run=0, write DEPTH+1 patterns -> STATUS full=1, count=16, overflow=1. Write STATUS -> overflow=0. The 17th pattern is never displayed.
- DWELL=2, CTRL=3 (run+loop), patterns A,B,C -> leds cycle A,A,B,B,C,C,A,... indefinitely with count stable at 3. A CPU write issued on a pop cycle sees waitrequest=1 for one cycle, then count=4.
- DWELL=0, CTRL=1, 4 patterns -> a new pattern appears every cycle (dwell treated as 1).
- Mid-SHOW: CTRL write with bit2=1 -> next edge count=0, busy=0, leds unchanged. Then assert reset mid-SHOW -> leds=0 immediately.
